dsc_slice_scheduler: RTL

Sequences one DSC picture as a grid of slices for the slice-level encoder/decoder core.
- On start it latches picture and slice geometry from the configuration, checks it, then issues one slice command per slice in raster order (left-to-right, top-to-bottom) over a valid/ready interface.
- It tracks completions with a bounded outstanding-slice counter and signals frame completion once every slice has retired.
- It sits between the frame-level control (register block or DPI-driven testbench top) and the DSC slice core.

---
 rtl/dsc_pkg.sv | 28 ++
 rtl/dsc_slice_scheduler_if.sv | 36 +++
 rtl/dsc_credit_ctr.sv | 44 ++++
 rtl/dsc_slice_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and constants for the DSC slice scheduling path.
//
// DSC_DIM_W  : width of picture/slice dimensions and coordinates
// DSC_IDX_W  : width of the raster slice index
// dsc_sched_state_t : scheduler FSM states
// dsc_slice_cmd_t   : one slice command as handed to the slice core
package dsc_pkg;

  localparam int DSC_DIM_W = 16;
  localparam int DSC_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } dsc_sched_state_t;

  typedef struct packed {
    logic [DSC_DIM_W-1:0] x;
    logic [DSC_DIM_W-1:0] y;
    logic [DSC_DIM_W-1:0] w;
    logic [DSC_DIM_W-1:0] h;
    logic [DSC_IDX_W-1:0] idx;
    logic                 last;
  } dsc_slice_cmd_t;

endpackage

// File: rtl/dsc_slice_scheduler_if.sv
// Slice command channel between the scheduler and the DSC slice core.
//
// cmd_valid/cmd_ready : command handshake (scheduler -> core)
// cmd_x/cmd_y         : slice top-left coordinate
// cmd_w/cmd_h         : effective slice size (clipped at picture edge)
// cmd_idx             : raster slice index
// cmd_last            : final slice of the picture
// slc_done            : one-cycle pulse from the core, one slice retired
//
// master : scheduler side, slave : slice core side
interface dsc_slice_scheduler_if #(
  parameter int DIM_W = dsc_pkg::DSC_DIM_W,
  parameter int IDX_W = dsc_pkg::DSC_IDX_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIM_W-1:0] cmd_x;
  logic [DIM_W-1:0] cmd_y;
  logic [DIM_W-1:0] cmd_w;
  logic [DIM_W-1:0] cmd_h;
  logic [IDX_W-1:0] cmd_idx;
  logic             cmd_last;
  logic             slc_done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_idx, cmd_last,
    input  cmd_ready, slc_done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_idx, cmd_last,
    output cmd_ready, slc_done
  );

endinterface

// File: rtl/dsc_credit_ctr.sv
// Outstanding-slice counter: counts slices issued but not yet retired.
//
// clk, rst_n : clock, asynchronous active-low reset
// clr        : synchronous clear (abort), highest priority
// inc        : one slice issued this cycle
// dec        : one slice retired this cycle (ignored when count is 0)
// count      : current outstanding count, 0..MAX_OUTST
// avail      : another slice may be issued (count < MAX_OUTST)
module dsc_credit_ctr
  import dsc_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int OUTST_W   = $clog2(MAX_OUTST + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  output logic [OUTST_W-1:0] count,
  output logic               avail
);

  localparam logic [OUTST_W-1:0] MAX_CNT = OUTST_W'(MAX_OUTST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      case ({inc, dec})
        2'b10: if (count != MAX_CNT) count <= count + 1'b1;
        2'b01: if (count != '0) count <= count - 1'b1;
        // A retire with nothing outstanding is spurious, so the issue still counts.
        2'b11: if (count == '0) count <= OUTST_W'(1);
        default: ;
      endcase
    end
  end

  assign avail = (count < MAX_CNT);

endmodule

// File: rtl/dsc_slice_scheduler.sv
// Issues one DSC picture as a raster-ordered grid of slice commands.
//
// clk, rst_n  : clock, asynchronous active-low reset
// start       : one-cycle request to run a picture (only honoured in IDLE)
// abort       : one-cycle abort, wins over everything else
// cfg_pic_w/h : picture size, latched on accepted start
// cfg_slice_w/h : nominal slice size, latched on accepted start
// busy        : scheduler is not IDLE
// cfg_err     : one-cycle pulse, latched geometry rejected
// frame_done  : one-cycle pulse, every slice issued and retired
// cmd         : slice command channel (master side)
//
// DIM_W and IDX_W must match DSC_DIM_W / DSC_IDX_W because the command
// register uses the shared dsc_slice_cmd_t layout.
module dsc_slice_scheduler
  import dsc_pkg::*;
#(
  parameter int DIM_W     = DSC_DIM_W,
  parameter int IDX_W     = DSC_IDX_W,
  parameter int MAX_OUTST = 4,
  parameter int OUTST_W   = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_pic_w,
  input  logic [DIM_W-1:0] cfg_pic_h,
  input  logic [DIM_W-1:0] cfg_slice_w,
  input  logic [DIM_W-1:0] cfg_slice_h,
  output logic             busy,
  output logic             cfg_err,
  output logic             frame_done,
  dsc_slice_scheduler_if.master cmd
);

  dsc_sched_state_t state, state_nxt;

  logic [DIM_W-1:0] pic_w, pic_h, slc_w, slc_h;
  dsc_slice_cmd_t   cmd_q;

  logic [OUTST_W-1:0] outst;
  logic               avail;
  logic               xfer;
  logic               cfg_ok;
  logic               drain_ok;

  logic [DIM_W:0]     x_sum, y_sum;
  logic               x_wrap;
  logic [DIM_W-1:0]   x_nxt, y_nxt;

  function automatic logic [DIM_W-1:0] min_dim(input logic [DIM_W-1:0] a,
                                               input logic [DIM_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Build the command for the slice whose top-left corner is (x, y).
  function automatic dsc_slice_cmd_t make_cmd(input logic [DIM_W-1:0] x,
                                              input logic [DIM_W-1:0] y,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [DIM_W-1:0] pw,
                                              input logic [DIM_W-1:0] ph,
                                              input logic [DIM_W-1:0] sw,
                                              input logic [DIM_W-1:0] sh);
    dsc_slice_cmd_t c;
    logic [DIM_W:0] x_end, y_end;
    x_end  = {1'b0, x} + {1'b0, sw};
    y_end  = {1'b0, y} + {1'b0, sh};
    c.x    = x;
    c.y    = y;
    c.w    = min_dim(sw, pw - x);
    c.h    = min_dim(sh, ph - y);
    c.idx  = idx;
    c.last = (x_end >= {1'b0, pw}) && (y_end >= {1'b0, ph});
    return c;
  endfunction

  dsc_credit_ctr #(
    .MAX_OUTST (MAX_OUTST),
    .OUTST_W   (OUTST_W)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .inc   (xfer),
    .dec   (cmd.slc_done),
    .count (outst),
    .avail (avail)
  );

  assign cfg_ok = (pic_w != '0) && (pic_h != '0) && (slc_w != '0) && (slc_h != '0) &&
                  (slc_w <= pic_w) && (slc_h <= pic_h);

  assign cmd.cmd_valid = (state == ISSUE) && avail;
  assign xfer          = cmd.cmd_valid && cmd.cmd_ready;

  // A retire arriving in DRAIN with one slice left empties the pipe now.
  assign drain_ok = (state == DRAIN) &&
                    ((outst == '0) || ((outst == OUTST_W'(1)) && cmd.slc_done));

  // Next raster position, computed one bit wider so the wrap compare cannot overflow.
  assign x_sum  = {1'b0, cmd_q.x} + {1'b0, slc_w};
  assign y_sum  = {1'b0, cmd_q.y} + {1'b0, slc_h};
  assign x_wrap = (x_sum >= {1'b0, pic_w});
  assign x_nxt  = x_wrap ? '0 : x_sum[DIM_W-1:0];
  assign y_nxt  = x_wrap ? y_sum[DIM_W-1:0] : cmd_q.y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = cfg_ok ? ISSUE : IDLE;
      ISSUE:   if (xfer && cmd_q.last) state_nxt = DRAIN;
      DRAIN:   if (drain_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Payload is fully registered so cmd_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pic_w      <= '0;
      pic_h      <= '0;
      slc_w      <= '0;
      slc_h      <= '0;
      cmd_q      <= '0;
      cfg_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cfg_err    <= (state == CHECK) && !cfg_ok && !abort;
      frame_done <= drain_ok && !abort;
      if ((state == IDLE) && start && !abort) begin
        pic_w <= cfg_pic_w;
        pic_h <= cfg_pic_h;
        slc_w <= cfg_slice_w;
        slc_h <= cfg_slice_h;
      end
      if ((state == CHECK) && cfg_ok) begin
        cmd_q <= make_cmd('0, '0, '0, pic_w, pic_h, slc_w, slc_h);
      end else if (xfer) begin
        cmd_q <= make_cmd(x_nxt, y_nxt, cmd_q.idx + 1'b1, pic_w, pic_h, slc_w, slc_h);
      end
    end
  end

  assign busy         = (state != IDLE);
  assign cmd.cmd_x    = cmd_q.x;
  assign cmd.cmd_y    = cmd_q.y;
  assign cmd.cmd_w    = cmd_q.w;
  assign cmd.cmd_h    = cmd_q.h;
  assign cmd.cmd_idx  = cmd_q.idx;
  assign cmd.cmd_last = cmd_q.last;

endmodule
